// File: rtl/ram_arb_pkg.sv
// Shared widths and requester identifiers for the two-port RAM arbiter.
package ram_arb_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 8;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last winner drops to lowest priority.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   req_id_t ptr_q, ptr_d;

   // Grants are suppressed while reset is asserted
   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      ptr_d  = ptr_q;
      if (rst_n) begin
         if (req[0] && (!req[1] || (ptr_q == REQ0))) begin
            gnt    = 2'b01;
            gnt_id = 1'b0;
            ptr_d  = REQ1;
         end else if (req[1]) begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
            ptr_d  = REQ0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= REQ0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_arb2.sv
// Serialises two masters onto one synchronous single-port RAM and routes
// read data back to the issuing master one cycle after its grant.
module ram_arb2
   import ram_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_w_en,
   input  logic [DATA_W-1:0] mem_dout
);

   logic [1:0]        gnt;
   logic              gnt_id;
   logic              win_we;
   logic              rd_pend_q, rd_pend_d;
   req_id_t           rd_tag_q, rd_tag_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({req1, req0}),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign gnt0   = gnt[0];
   assign gnt1   = gnt[1];
   assign win_we = gnt_id ? we1 : we0;

   // RAM port mux; idle cycles park the port at zero
   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_w_en = 1'b0;
      if (gnt[0]) begin
         mem_addr = addr0;
         mem_din  = wdata0;
         mem_w_en = we0;
      end else if (gnt[1]) begin
         mem_addr = addr1;
         mem_din  = wdata1;
         mem_w_en = we1;
      end
   end

   // Read tag: remembers who owns the data the RAM returns next cycle
   always_comb begin
      rd_pend_d = (|gnt) && !win_we;
      rd_tag_d  = req_id_t'(gnt_id);
   end

   assign rvalid0  = rd_pend_q && (rd_tag_q == REQ0);
   assign rvalid1  = rd_pend_q && (rd_tag_q == REQ1);
   assign rdata0_d = rvalid0 ? mem_dout : rdata0_q;
   assign rdata1_d = rvalid1 ? mem_dout : rdata1_q;
   assign rdata0   = rdata0_d;
   assign rdata1   = rdata1_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_q <= 1'b0;
         rd_tag_q  <= REQ0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_tag_q  <= rd_tag_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_ram_arb2.sv
// Bench for ram_arb2: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, RAM contents and read return.
module tb_ram_arb2;
   import ram_arb_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req0, we0, req1, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              mem_w_en;
   logic [DATA_W-1:0] mem_dout;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_arb2 dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_w_en(mem_w_en),
      .mem_dout(mem_dout)
   );

   // Behavioural ram_syn: registered read, write lands at the same edge
   logic [DATA_W-1:0] ram [1024];
   always @(posedge clk) begin
      if (mem_w_en) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [1024];
   int                m_fav;
   bit                m_pend;
   int                m_tag;
   logic [DATA_W-1:0] m_data, m_hold0, m_hold1;

   logic              o_gnt0, o_gnt1, o_rv0, o_rv1, o_wen;
   logic [DATA_W-1:0] o_rd0, o_rd1;
   logic [ADDR_W-1:0] o_maddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_fav   = 0;
      m_pend  = 1'b0;
      m_tag   = 0;
      m_hold0 = '0;
      m_hold1 = '0;
   endfunction

   // One clock cycle: drive, check mid-cycle at negedge, advance the model
   task automatic step(input logic r0, input logic w0, input int a0, input int d0,
                       input logic r1, input logic w1, input int a1, input int d1);
      int                win;
      logic              e_we;
      logic [ADDR_W-1:0] e_a;
      logic [DATA_W-1:0] e_d;
      req0 = r0; we0 = w0; addr0 = ADDR_W'(a0); wdata0 = DATA_W'(d0);
      req1 = r1; we1 = w1; addr1 = ADDR_W'(a1); wdata1 = DATA_W'(d1);
      @(negedge clk);
      win = -1;
      if (rst_n) begin
         if (r0 && r1) win = m_fav;
         else if (r0)  win = 0;
         else if (r1)  win = 1;
      end
      e_we = 1'b0; e_a = '0; e_d = '0;
      if (win == 0) begin e_we = w0; e_a = ADDR_W'(a0); e_d = DATA_W'(d0); end
      if (win == 1) begin e_we = w1; e_a = ADDR_W'(a1); e_d = DATA_W'(d1); end
      chk("gnt0", 32'(gnt0), 32'(win == 0));
      chk("gnt1", 32'(gnt1), 32'(win == 1));
      chk("mem_w_en", 32'(mem_w_en), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_a));
      chk("mem_din", 32'(mem_din), 32'(e_d));
      chk("rvalid0", 32'(rvalid0), 32'(m_pend && m_tag == 0));
      chk("rvalid1", 32'(rvalid1), 32'(m_pend && m_tag == 1));
      chk("rdata0", 32'(rdata0), 32'((m_pend && m_tag == 0) ? m_data : m_hold0));
      chk("rdata1", 32'(rdata1), 32'((m_pend && m_tag == 1) ? m_data : m_hold1));
      o_gnt0 = gnt0; o_gnt1 = gnt1; o_rv0 = rvalid0; o_rv1 = rvalid1;
      o_rd0 = rdata0; o_rd1 = rdata1; o_wen = mem_w_en; o_maddr = mem_addr;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_pend) begin
            if (m_tag == 0) m_hold0 = m_data;
            else            m_hold1 = m_data;
         end
         m_pend = 1'b0;
         if (win >= 0) begin
            if (e_we) ref_mem[e_a] = e_d;
            else begin
               m_pend = 1'b1;
               m_tag  = win;
               m_data = ref_mem[e_a];
            end
            m_fav = 1 - win;
         end
      end
      #1;
   endtask

   // Short asynchronous reset pulse in the middle of a cycle
   task automatic rst_pulse();
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'({gnt1, gnt0}), 32'(0));
      chk("rst_wen", 32'(mem_w_en), 32'(0));
      chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
      chk("rst_rdata", 32'({rdata1, rdata0}), 32'(0));
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic         act [2];
      logic         rwe [2];
      int           ra  [2];
      int           rd  [2];
      rst_n = 1'b0;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = DATA_W'($urandom);
         ref_mem[i] = ram[i];
      end
      model_reset();
      m_data = '0;
      #1;

      // Reset held with both masters requesting
      step(1, 0, 5, 0, 1, 0, 6, 0);
      step(1, 0, 5, 0, 1, 0, 6, 0);
      rst_n = 1'b1;
      step(1, 0, 5, 0, 1, 0, 6, 0);
      chk("first_gnt0", 32'(o_gnt0), 32'(1));
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Single-master write then read
      step(1, 1, 1010, 210, 0, 0, 0, 0);
      chk("t2_wen", 32'(o_wen), 32'(1));
      chk("t2_addr", 32'(o_maddr), 32'(1010));
      step(1, 0, 1010, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_rv0", 32'(o_rv0), 32'(1));
      chk("t2_rd0", 32'(o_rd0), 32'(210));
      chk("t2_rv1", 32'(o_rv1), 32'(0));

      // Contention: preload, then both hold reads for six cycles
      step(1, 1, 1000, 110, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 788, 158);
      for (int k = 0; k < 6; k++) begin
         step(1, 0, 1000, 0, 1, 0, 788, 0);
         chk("t3_alt", 32'(o_gnt0), 32'(k % 2 == 0));
         if (k > 0) begin
            chk("t3_rv", 32'({o_rv1, o_rv0}), 32'((k % 2 == 0) ? 2'b10 : 2'b01));
            if (k % 2 == 1) chk("t3_rd0", 32'(o_rd0), 32'(110));
            else            chk("t3_rd1", 32'(o_rd1), 32'(158));
         end
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t3_last_rd1", 32'(o_rd1), 32'(158));

      // Write-then-read hazard across masters
      step(0, 0, 0, 0, 1, 1, 888, 144);
      step(1, 0, 888, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4_rv0", 32'(o_rv0), 32'(1));
      chk("t4_rd0", 32'(o_rd0), 32'(144));

      // Fairness after a lone requester-1 grant
      step(0, 0, 0, 0, 1, 1, 666, 9);
      step(1, 0, 666, 0, 1, 0, 666, 0);
      chk("t5_gnt0", 32'(o_gnt0), 32'(1));
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset while a read is in flight
      step(1, 0, 1023, 0, 0, 0, 0, 0);
      req0 = 1'b0;
      rst_pulse();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_rv0", 32'(o_rv0), 32'(0));
      step(1, 0, 3, 0, 1, 0, 4, 0);
      chk("t6_ptr", 32'(o_gnt0), 32'(1));
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic with abandons, narrow address range for hazards
      for (int i = 0; i < 2; i++) act[i] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (act[i] && $urandom_range(0, 15) == 0) act[i] = 1'b0;
            else if (!act[i] && $urandom_range(0, 1) == 1) begin
               act[i] = 1'b1;
               rwe[i] = 1'($urandom_range(0, 1));
               ra[i]  = int'($urandom_range(0, 15)) + (($urandom_range(0, 7) == 0) ? 1008 : 0);
               rd[i]  = int'($urandom_range(0, 255));
            end
         end
         if ($urandom_range(0, 499) == 0) rst_pulse();
         step(act[0], rwe[0], ra[0], rd[0], act[1], rwe[1], ra[1], rd[1]);
         if (o_gnt0) act[0] = 1'b0;
         if (o_gnt1) act[1] = 1'b0;
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
